// File: rtl/latch_edge_monitor.sv
// Synchronises the asynchronous d_latch output, filters glitches with a stability window,
// and reports saturating rise/fall counts over a valid/ready snapshot handshake.
module latch_edge_monitor #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             q_in,
    input  logic             snap,
    output logic             q_filt,
    output logic             rise,
    output logic             fall,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_rise,
    output logic [CNT_W-1:0] rpt_fall,
    output logic             rpt_sat
);

    localparam int unsigned         FCNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rpt_state_e;

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              q_filt_q, q_filt_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [CNT_W-1:0]  rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0]  fall_cnt_q, fall_cnt_d;
    logic [CNT_W-1:0]  rpt_rise_q, rpt_rise_d;
    logic [CNT_W-1:0]  rpt_fall_q, rpt_fall_d;
    logic              rpt_sat_q, rpt_sat_d;
    rpt_state_e        state_q, state_d;

    logic toggle;
    logic rise_ev;
    logic fall_ev;
    logic capture;

    // Synchroniser and stability filter: a single matching cycle restarts the window.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_d     = q_in;
        s2_d     = s1_q;
        toggle   = 1'b0;
        fcnt_d   = '0;
        q_filt_d = q_filt_q;
        if (s2_q != q_filt_q) begin
            if (fcnt_q == FCNT_LAST) begin
                toggle   = 1'b1;
                q_filt_d = ~q_filt_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
        rise_ev = toggle & ~q_filt_q;
        fall_ev = toggle &  q_filt_q;
        rise_d  = rise_ev;
        fall_d  = fall_ev;
    end

    // Report FSM; a capture clears the live counters but keeps a same-cycle edge.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        rpt_rise_d = rpt_rise_q;
        rpt_fall_d = rpt_fall_q;
        rpt_sat_d  = rpt_sat_q;
        case (state_q)
            IDLE: begin
                if (snap) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rpt_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (capture) begin
            rpt_rise_d = rise_cnt_q;
            rpt_fall_d = fall_cnt_q;
            rpt_sat_d  = (rise_cnt_q == CNT_MAX) || (fall_cnt_q == CNT_MAX);
        end

        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        if (capture) begin
            rise_cnt_d = CNT_W'(rise_ev);
            fall_cnt_d = CNT_W'(fall_ev);
        end else begin
            if (rise_ev && (rise_cnt_q != CNT_MAX)) rise_cnt_d = rise_cnt_q + CNT_W'(1);
            if (fall_ev && (fall_cnt_q != CNT_MAX)) fall_cnt_d = fall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            fcnt_q     <= '0;
            q_filt_q   <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
            rpt_rise_q <= '0;
            rpt_fall_q <= '0;
            rpt_sat_q  <= 1'b0;
            state_q    <= IDLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            fcnt_q     <= fcnt_d;
            q_filt_q   <= q_filt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            rpt_rise_q <= rpt_rise_d;
            rpt_fall_q <= rpt_fall_d;
            rpt_sat_q  <= rpt_sat_d;
            state_q    <= state_d;
        end
    end

    assign q_filt    = q_filt_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign rpt_valid = (state_q == HOLD);
    assign rpt_rise  = rpt_rise_q;
    assign rpt_fall  = rpt_fall_q;
    assign rpt_sat   = rpt_sat_q;

endmodule

// File: tb/tb_latch_edge_monitor.sv
// Directed bench for latch_edge_monitor: expected reports are queued at snapshot time and
// a negedge monitor pops and compares them whenever a report handshake completes.
module tb_latch_edge_monitor;

    localparam int unsigned FL = 4;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] f;
        logic          s;
    } rpt_t;

    logic          clk = 1'b0;
    logic          clr;
    logic          q_in;
    logic          snap;
    logic          q_filt;
    logic          rise;
    logic          fall;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [CW-1:0] rpt_rise;
    logic [CW-1:0] rpt_fall;
    logic          rpt_sat;

    int   checks   = 0;
    int   failures = 0;
    rpt_t sb_q[$];
    rpt_t exp_last;
    logic [CW-1:0] m_rise = '0;
    logic [CW-1:0] m_fall = '0;

    latch_edge_monitor #(.FILTER_LEN(FL), .CNT_W(CW)) dut (
        .clk       (clk),
        .clr       (clr),
        .q_in      (q_in),
        .snap      (snap),
        .q_filt    (q_filt),
        .rise      (rise),
        .fall      (fall),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_rise  (rpt_rise),
        .rpt_fall  (rpt_fall),
        .rpt_sat   (rpt_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] c);
        return (c == '1) ? c : c + CW'(1);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // q_in was just changed: toggle must land exactly on edge 2+FL.
    task automatic wait_toggle(input logic v);
        step(1 + FL);
        check("pre_toggle_level", q_filt, !v);
        step(1);
        check("toggle_level", q_filt, v);
        check("rise_pulse", rise, v);
        check("fall_pulse", fall, !v);
        step(1);
        check("pulse_clear", {rise, fall}, 0);
        if (v) m_rise = inc_sat(m_rise);
        else   m_fall = inc_sat(m_fall);
    endtask

    task automatic drive_level(input logic v);
        q_in = v;
        wait_toggle(v);
    endtask

    task automatic snap_req();
        exp_last = '{r: m_rise, f: m_fall, s: (m_rise == '1) || (m_fall == '1)};
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        sb_q.push_back(exp_last);
        m_rise = '0;
        m_fall = '0;
        check("snap_valid", rpt_valid, 1);
    endtask

    task automatic accept();
        rpt_ready = 1'b1;
        step(1);
        rpt_ready = 1'b0;
        check("accept_drop", rpt_valid, 0);
    endtask

    task automatic check_fields(input string name);
        check(name, {rpt_valid, rpt_rise, rpt_fall, rpt_sat}, {1'b1, exp_last});
    endtask

    // Scoreboard monitor: a handshake completes at the next edge when valid && ready.
    always @(negedge clk) begin
        if (clr === 1'b1) begin
            check("pulse_exclusive", {31'd0, rise & fall}, 0);
            if (rpt_valid && rpt_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_report", 1, 0);
                end else begin
                    rpt_t e;
                    e = sb_q.pop_front();
                    check("report_fields", {rpt_rise, rpt_fall, rpt_sat}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b1; q_in = 1'b1; snap = 1'b0; rpt_ready = 1'b0;
        #1 clr = 1'b0;
        #2;
        check("async_reset_outputs",
              {q_filt, rise, fall, rpt_valid, rpt_rise, rpt_fall, rpt_sat}, 0);
        step(3);
        check("reset_held", {q_filt, rise, fall, rpt_valid}, 0);
        clr = 1'b1;
        wait_toggle(1'b1);

        // Glitch rejection: 3-cycle high pulse must not move q_filt.
        drive_level(1'b0);
        begin
            int n_rise = 0;
            q_in = 1'b1;
            step(3);
            q_in = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (rise) n_rise++;
                step(1);
            end
            check("glitch_no_rise", n_rise, 0);
            check("glitch_level", q_filt, 0);
        end
        drive_level(1'b1);
        begin
            int extra = 0;
            for (int i = 0; i < 8; i++) begin
                if (rise) extra++;
                step(1);
            end
            check("single_rise", extra, 0);
        end
        drive_level(1'b0);
        snap_req();
        accept();

        // Count and snapshot: 3 rises, 2 falls, report held with ready low.
        drive_level(1'b1); drive_level(1'b0); drive_level(1'b1);
        drive_level(1'b0); drive_level(1'b1);
        snap_req();
        check_fields("count_fields");
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_fields("hold_stable");
        end
        accept();

        // Saturation: 20 fall/rise pairs.
        for (int i = 0; i < 20; i++) begin
            drive_level(1'b0);
            drive_level(1'b1);
        end
        snap_req();
        check_fields("sat_fields");
        accept();

        // Snapshot on the same edge as a rise pulse.
        drive_level(1'b0); drive_level(1'b1); drive_level(1'b0);
        drive_level(1'b1); drive_level(1'b0);
        q_in = 1'b1;
        step(1 + FL);
        exp_last = '{r: m_rise, f: m_fall, s: 1'b0};
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        sb_q.push_back(exp_last);
        m_rise = CW'(1);
        m_fall = '0;
        check("simul_rise", {rise, q_filt, rpt_valid}, 3'b111);
        check_fields("simul_fields");
        accept();
        snap_req();
        check_fields("simul_second");
        accept();

        // HOLD: snap ignored, edges accumulate into the next report.
        drive_level(1'b0);
        snap_req();
        for (int i = 0; i < 3; i++) begin
            snap = 1'b1;
            step(1);
            snap = 1'b0;
            step(1);
            check_fields("hold_snap_ignored");
        end
        drive_level(1'b1);
        drive_level(1'b0);
        check_fields("hold_edges_frozen");
        accept();
        snap_req();
        check_fields("hold_next_report");
        accept();

        // Reset in the middle of HOLD discards the report.
        drive_level(1'b1);
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        check("pending_valid", rpt_valid, 1);
        clr = 1'b0;
        #1;
        check("clr_mid_hold",
              {q_filt, rise, fall, rpt_valid, rpt_rise, rpt_fall, rpt_sat}, 0);
        m_rise = '0;
        m_fall = '0;
        q_in = 1'b0;
        step(2);
        clr = 1'b1;
        step(8);
        check("post_reset_level", q_filt, 0);
        snap_req();
        check_fields("post_reset_counts");
        accept();

        step(3);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
